// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: MMIO bus and CP0 handshake between the bridge/CPU and the
// interrupt arbiter.
//   we       bridge write strobe
//   addr     byte address within the block; [4:2] selects the register
//   wdata    write data
//   rdata    combinational read data from the arbiter
//   cp0_req  CP0 Req, high the cycle the CPU takes an exception/interrupt
//   hwint    registered one-hot (or zero) interrupt request to CP0 HWInt
interface irq_arbiter_if #(
    parameter int N_SRC = 6
);
    logic             we;
    logic [4:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             cp0_req;
    logic [N_SRC-1:0] hwint;

    modport master (
        output we, addr, wdata, cp0_req,
        input  rdata, hwint
    );

    modport slave (
        input  we, addr, wdata, cp0_req,
        output rdata, hwint
    );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: interrupt controller between peripherals and CP0.
// Synchronises raw irq lines, latches them as pending (edge or level per
// source), picks the lowest-index eligible source, drives it one-hot on
// HWInt and holds it through service until the handler writes EOI.
//   clk     system clock
//   reset   asynchronous, active-high reset
//   irq_in  raw interrupt lines, asynchronous to clk
//   bus     MMIO access (we/addr/wdata/rdata) and CP0 handshake
//           (cp0_req in, hwint out)
// Registers (addr[4:2]): 0 MASK rw, 1 MODE rw (1=edge), 2 PEND r/W1C,
// 3 STATUS r ([9:8] state, [7] active_valid, [2:0] active_id), 4 EOI w.
module irq_arbiter #(
    parameter int N_SRC       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    irq_arbiter_if.slave     bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [2:0] REG_MASK   = 3'd0;
    localparam logic [2:0] REG_MODE   = 3'd1;
    localparam logic [2:0] REG_PEND   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_EOI    = 3'd4;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] irq_s;
    logic [N_SRC-1:0] irq_d;
    logic [N_SRC-1:0] rise;

    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] eligible;
    logic [7:0]       eligible_w;

    logic [1:0]       state;
    logic [2:0]       active_id;
    logic [N_SRC-1:0] hwint_q;

    logic [2:0]       winner;
    logic             any_eligible;

    logic [2:0]       reg_sel;
    logic             wr_mask;
    logic             wr_mode;
    logic             wr_pend;
    logic             eoi_fire;
    logic [31:0]      rdata_c;

    logic             unused_bits;

    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:N_SRC]};

    // ------------------------------------------------------------------
    // Synchroniser and edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            irq_d <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            irq_d <= irq_s;
        end
    end

    assign irq_s = sync_q[SYNC_STAGES-1];
    assign rise  = irq_s & ~irq_d;

    // ------------------------------------------------------------------
    // MMIO decode
    // ------------------------------------------------------------------
    assign reg_sel  = bus.addr[4:2];
    assign wr_mask  = bus.we && (reg_sel == REG_MASK);
    assign wr_mode  = bus.we && (reg_sel == REG_MODE);
    assign wr_pend  = bus.we && (reg_sel == REG_PEND);
    // EOI only acts while a source is in service.
    assign eoi_fire = bus.we && (reg_sel == REG_EOI) && (state == ST_SERVICE);

    always_comb begin
        rdata_c = '0;
        case (reg_sel)
            REG_MASK:   rdata_c = 32'(mask);
            REG_MODE:   rdata_c = 32'(mode);
            REG_PEND:   rdata_c = 32'(pend);
            REG_STATUS: rdata_c = {22'd0, state, (state != ST_IDLE), 4'd0, active_id};
            default:    rdata_c = '0;
        endcase
    end

    assign bus.rdata = rdata_c;
    assign bus.hwint = hwint_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask <= '0;
            mode <= '0;
        end else begin
            if (wr_mask) mask <= bus.wdata[N_SRC-1:0];
            if (wr_mode) mode <= bus.wdata[N_SRC-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Pending latch: level sources track irq_s; edge sources set on rise
    // and clear on W1C or EOI of the active id, with set winning.
    // ------------------------------------------------------------------
    always_comb begin
        pend_clr = wr_pend ? bus.wdata[N_SRC-1:0] : '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (eoi_fire && (active_id == 3'(i))) begin
                pend_clr[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pend_nxt = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (mode[i]) begin
                pend_nxt[i] = rise[i] | (pend[i] & ~pend_clr[i]);
            end else begin
                pend_nxt[i] = irq_s[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Fixed-priority selection, index 0 highest
    // ------------------------------------------------------------------
    assign eligible     = pend & mask;
    assign any_eligible = |eligible;
    // Widened so active_id can index it for any legal N_SRC.
    assign eligible_w   = 8'(eligible);

    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            active_id <= '0;
            hwint_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_eligible) begin
                        active_id <= winner;
                        hwint_q   <= N_SRC'(1) << winner;
                        state     <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (bus.cp0_req) begin
                        hwint_q <= '0;
                        state   <= ST_SERVICE;
                    end else if (!eligible_w[active_id]) begin
                        hwint_q <= '0;
                        state   <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    hwint_q <= '0;
                    if (eoi_fire) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    hwint_q <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

    logic       clk;
    logic       reset;
    logic [5:0] irq_in;
    int         total;
    int         bad;

    irq_arbiter_if #(.N_SRC(6)) bus ();

    irq_arbiter #(
        .N_SRC(6),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .irq_in(irq_in),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mmio_write(input logic [2:0] r, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = {r, 2'b00};
        bus.wdata = d;
        step();
        bus.we    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] r, input logic [31:0] exp);
        bus.addr = {r, 2'b00};
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic status_chk(input string tag, input logic [1:0] st, input logic vld,
                              input logic [2:0] id);
        logic [31:0] s;
        bus.addr = {3'd3, 2'b00};
        #1;
        s = bus.rdata;
        chk({tag, ".state"}, 32'(s[9:8]), 32'(st));
        chk({tag, ".valid"}, 32'(s[7]), 32'(vld));
        chk({tag, ".id"}, 32'(s[2:0]), 32'(id));
    endtask

    task automatic cp0_pulse();
        bus.cp0_req = 1'b1;
        step();
        bus.cp0_req = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        irq_in      = '0;
        bus.we      = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.cp0_req = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Async reset mid-cycle clears registers without a clock edge
        mmio_write(3'd0, 32'h3F);
        mmio_write(3'd1, 32'h15);
        rd_chk("mask_rb", 3'd0, 32'h3F);
        rd_chk("mode_rb", 3'd1, 32'h15);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_hwint", 32'(bus.hwint), 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
        end
        step();
        reset = 1'b0;
        step();

        // Edge latency and full service cycle on source 0
        mmio_write(3'd0, 32'h3F);
        mmio_write(3'd1, 32'h01);
        irq_in = 6'b000001;
        step();
        step();
        rd_chk("lat_pend_k1", 3'd2, 32'h00);
        step();
        rd_chk("lat_pend_k2", 3'd2, 32'h01);
        chk("lat_hwint_k2", 32'(bus.hwint), 32'h00);
        step();
        chk("lat_hwint_k3", 32'(bus.hwint), 32'h01);
        status_chk("lat_status", 2'd1, 1'b1, 3'd0);
        cp0_pulse();
        step();
        chk("svc_hwint", 32'(bus.hwint), 32'h00);
        status_chk("svc_status", 2'd2, 1'b1, 3'd0);
        mmio_write(3'd4, 32'h0);
        rd_chk("eoi_pend", 3'd2, 32'h00);
        rd_chk("eoi_status", 3'd3, 32'h00);
        irq_in = '0;
        repeat (3) step();

        // Priority without preemption
        mmio_write(3'd1, 32'h3F);
        irq_in = 6'b101000;
        repeat (4) step();
        chk("pri_first", 32'(bus.hwint), 32'h08);
        irq_in = 6'b101010;
        repeat (4) step();
        chk("pri_nopreempt", 32'(bus.hwint), 32'h08);
        rd_chk("pri_pend", 3'd2, 32'h2A);
        cp0_pulse();
        mmio_write(3'd4, 32'h0);
        rd_chk("pri_pend_after", 3'd2, 32'h22);
        step();
        chk("pri_second", 32'(bus.hwint), 32'h02);
        cp0_pulse();
        mmio_write(3'd4, 32'h0);
        step();
        chk("pri_third", 32'(bus.hwint), 32'h20);
        status_chk("pri_third_st", 2'd1, 1'b1, 3'd5);
        cp0_pulse();
        mmio_write(3'd4, 32'h0);
        irq_in = '0;
        repeat (3) step();
        rd_chk("pri_pend_empty", 3'd2, 32'h00);

        // EOI in ASSERT is ignored
        irq_in = 6'b000100;
        repeat (4) step();
        chk("eoi_ign_hwint0", 32'(bus.hwint), 32'h04);
        mmio_write(3'd4, 32'h0);
        step();
        chk("eoi_ign_hwint", 32'(bus.hwint), 32'h04);
        rd_chk("eoi_ign_pend", 3'd2, 32'h04);
        cp0_pulse();
        mmio_write(3'd4, 32'h0);
        irq_in = '0;
        repeat (3) step();

        // Spurious withdrawal of a level source by masking
        mmio_write(3'd1, 32'h00);
        irq_in = 6'b000100;
        repeat (4) step();
        chk("spur_hwint", 32'(bus.hwint), 32'h04);
        mmio_write(3'd0, 32'h3B);
        step();
        chk("spur_drop", 32'(bus.hwint), 32'h00);
        status_chk("spur_status", 2'd0, 1'b0, 3'd2);
        rd_chk("spur_pend", 3'd2, 32'h04);
        irq_in = '0;
        mmio_write(3'd0, 32'h3F);
        repeat (3) step();
        rd_chk("spur_pend_gone", 3'd2, 32'h00);

        // Set/clear collision on edge source 4: set wins; then W1C clears
        mmio_write(3'd1, 32'h10);
        irq_in = 6'b010000;
        step();
        step();
        mmio_write(3'd2, 32'h10);
        rd_chk("coll_pend", 3'd2, 32'h10);
        step();
        chk("coll_hwint", 32'(bus.hwint), 32'h10);
        mmio_write(3'd2, 32'h10);
        rd_chk("w1c_pend", 3'd2, 32'h00);
        step();
        chk("w1c_hwint", 32'(bus.hwint), 32'h00);
        status_chk("w1c_status", 2'd0, 1'b0, 3'd4);
        irq_in = '0;
        repeat (3) step();

        // Level source held across EOI re-arbitrates immediately
        mmio_write(3'd1, 32'h00);
        irq_in = 6'b000001;
        repeat (4) step();
        chk("lvl_hwint", 32'(bus.hwint), 32'h01);
        cp0_pulse();
        step();
        chk("lvl_svc", 32'(bus.hwint), 32'h00);
        mmio_write(3'd4, 32'h0);
        status_chk("lvl_idle", 2'd0, 1'b0, 3'd0);
        rd_chk("lvl_pend", 3'd2, 32'h01);
        step();
        chk("lvl_rearb", 32'(bus.hwint), 32'h01);
        status_chk("lvl_rearb_st", 2'd1, 1'b1, 3'd0);
        irq_in = '0;
        repeat (4) step();
        chk("lvl_withdraw", 32'(bus.hwint), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
